// File: rtl/matmul_feed_controller.sv
// matmul_feed_controller: feeds N skewed operand lanes into the systolic array, with clear/drain/done sequencing.
// Optional MATMUL_FEED_STALL_CNT_EN builds the FEED stall counter; otherwise stall_count is tied to 0.
module matmul_feed_controller #(
    parameter int N  = 3,
    parameter int W  = 16,
    parameter int KW = 8
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    output logic            arr_clear,
    output logic            arr_en,
    output logic [N*W-1:0]  arr_data,
    output logic [N-1:0]    arr_valid,
    output logic            busy,
    output logic            done,
    output logic [15:0]     stall_count
);
    localparam int DW = $clog2(N + 1);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
    state_t        state;
    logic [KW-1:0] k_lat, beat_cnt;
    logic [DW-1:0] drain_cnt;
    logic          xfer, sh, go;
    assign xfer = state == FEED && in_valid;
    assign sh   = xfer || state == DRAIN;
    assign go   = state == IDLE && start && k_len != '0;
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            k_lat     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            in_ready  <= 1'b0;
            arr_clear <= 1'b0;
            arr_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            arr_clear <= 1'b0;
            done      <= 1'b0;
            arr_en    <= sh;
            case (state)
                IDLE: if (go) begin
                    k_lat     <= k_len;
                    beat_cnt  <= '0;
                    drain_cnt <= '0;
                    arr_clear <= 1'b1;
                    busy      <= 1'b1;
                    state     <= CLEAR;
                end
                CLEAR: begin
                    in_ready <= 1'b1;
                    state    <= FEED;
                end
                FEED: if (in_valid) begin
                    if (beat_cnt != k_lat) beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt == k_lat - 1'b1) begin
                        in_ready <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DW'(N - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // lane i is an (i+1)-deep chain; all lanes shift together so a stall keeps the diagonal intact
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] d [0:i];
        logic [i:0]   v;
        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                for (int k = 0; k <= i; k++) d[k] <= '0;
                v <= '0;
            end else if (sh) begin
                d[0] <= xfer ? in_data[i*W +: W] : '0;
                v[0] <= xfer;
                for (int k = 1; k <= i; k++) begin
                    d[k] <= d[k-1];
                    v[k] <= v[k-1];
                end
            end
        end
        assign arr_data[i*W +: W] = d[i];
        assign arr_valid[i]       = v[i];
    end
`ifdef MATMUL_FEED_STALL_CNT_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) stall_count <= '0;
        else if (go) stall_count <= '0;
        else if (state == FEED && !in_valid && stall_count != 16'hFFFF) stall_count <= stall_count + 1'b1;
    end
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_matmul_feed_controller.sv
// tb_matmul_feed_controller: scoreboard bench for matmul_feed_controller (N=3, W=16, KW=8).
module tb_matmul_feed_controller;
    localparam int N = 3;
    localparam int W = 16;
    localparam int KW = 8;
`ifdef MATMUL_FEED_STALL_CNT_EN
    localparam int STALL_ON = 1;
`else
    localparam int STALL_ON = 0;
`endif
    logic            Clock, Reset_n, start, in_valid, in_ready;
    logic [KW-1:0]   k_len;
    logic [N*W-1:0]  in_data, arr_data;
    logic [N-1:0]    arr_valid;
    logic            arr_clear, arr_en, busy, done;
    logic [15:0]     stall_count;
    int checks = 0, failures = 0;
    logic [W-1:0]    sbq [N][$];
    logic [N*W-1:0]  lg_data [0:1023];
    logic [N-1:0]    lg_valid [0:1023];
    logic            lg_en [0:1023];
    logic            lg_clr [0:1023];
    matmul_feed_controller #(.N(N), .W(W), .KW(KW)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .arr_clear(arr_clear), .arr_en(arr_en), .arr_data(arr_data), .arr_valid(arr_valid),
        .busy(busy), .done(done), .stall_count(stall_count)
    );
    initial begin
        Clock = 0;
        forever #5 Clock = ~Clock;
    end
    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // record every accepted beat just before the edge that takes it
    always @(negedge Clock)
        if (Reset_n && in_valid && in_ready)
            for (int i = 0; i < N; i++) sbq[i].push_back(in_data[i*W +: W]);
    always @(posedge Clock) begin
        #2;
        if (Reset_n && arr_en)
            for (int i = 0; i < N; i++) begin
                if (!arr_valid[i]) check("filler_zero", 48'(arr_data[i*W +: W]), 48'h0);
                else if (sbq[i].size() == 0) check("sb_underflow", 48'h0, 48'h1);
                else check("lane_data", 48'(arr_data[i*W +: W]), 48'(sbq[i].pop_front()));
            end
    end
    function automatic logic [N*W-1:0] beat(input int j);
        logic [N*W-1:0] b;
        for (int i = 0; i < N; i++) b[i*W +: W] = W'(i * 256 + j + 1);
        return b;
    endfunction
    task automatic run(input int k, input int stall_at, input int stall_n, input bit poke,
                       output int dcyc, output int bcnt, output int ccnt);
        int sent, st, cyc;
        sent = 0; st = 0; cyc = 1; dcyc = -1; bcnt = 0; ccnt = 0;
        @(posedge Clock); #1;
        start = 1; k_len = KW'(k);
        @(posedge Clock); #1;
        start = 0; k_len = 8'd9;
        while (dcyc < 0 && cyc < 1000) begin
            lg_data[cyc] = arr_data; lg_valid[cyc] = arr_valid;
            lg_en[cyc] = arr_en; lg_clr[cyc] = arr_clear;
            bcnt += int'(busy); ccnt += int'(arr_clear);
            if (done) dcyc = cyc;
            start = poke && cyc == 3;
            if (in_ready && sent == stall_at && st < stall_n) begin
                in_valid = 0; st++;
            end else begin
                in_valid = 1;
                in_data = in_ready ? beat(sent) : {N{16'hDEAD}};
                if (in_ready) sent++;
            end
            if (dcyc < 0) begin
                @(posedge Clock); #1;
                cyc++;
            end
        end
        if (dcyc < 0) check("done_timeout", 48'h0, 48'h1);
        in_valid = 0; start = 0;
    endtask
    function automatic int en_gaps(input int dcyc);
        int g = 0;
        for (int c = 3; c <= dcyc; c++) g += int'(!lg_en[c]);
        return g;
    endfunction
    initial begin
        int d, b, c, cnt;
        Reset_n = 0; start = 0; k_len = 0; in_valid = 0; in_data = 0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_ctrl", 48'({in_ready, arr_clear, arr_en, busy, done, arr_valid}), 48'h0);
        check("rst_data", 48'(arr_data), 48'h0);
        check("rst_stall", 48'(stall_count), 48'h0);
        Reset_n = 1;
        // basic run with a start poke during FEED
        run(4, 0, 0, 1, d, b, c);
        check("basic_done_cyc", 48'(d), 48'd9);
        check("basic_busy", 48'(b), 48'd9);
        check("basic_clr_cnt", 48'(c), 48'd1);
        check("basic_clr_c1", 48'(lg_clr[1]), 48'h1);
        check("lane0_first", 48'(lg_data[3][15:0]), 48'h0001);
        check("lane0_en", 48'(lg_en[3]), 48'h1);
        check("lane2_first", 48'(lg_data[5][47:32]), 48'h0201);
        check("drain_v0", 48'(lg_valid[6]), 48'h7);
        check("drain_v1", 48'(lg_valid[7]), 48'h6);
        check("drain_v2", 48'(lg_valid[8]), 48'h4);
        check("drain_v3", 48'(lg_valid[9]), 48'h0);
        check("drain_fill", 48'(lg_data[8][31:0]), 48'h0);
        check("done_en", 48'(lg_en[9]), 48'h1);
        check("done_data", 48'(lg_data[9]), 48'h0);
        check("basic_gaps", 48'(en_gaps(d)), 48'd0);
        check("basic_sb", 48'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 48'd0);
        // back-to-back start in the cycle after done, new k_len
        run(3, 0, 0, 0, d, b, c);
        check("b2b_done_cyc", 48'(d), 48'd8);
        check("b2b_busy", 48'(b), 48'd8);
        check("b2b_clr", 48'(lg_clr[1]), 48'h1);
        // stall of 3 cycles between the two beats
        run(2, 1, 3, 0, d, b, c);
        check("stall_done_cyc", 48'(d), 48'd10);
        check("stall_gaps", 48'(en_gaps(d)), 48'd3);
        check("stall_frozen", 48'(lg_valid[6]), 48'h1);
        check("stall_align", 48'(lg_data[7][31:0]), 48'h0101_0002);
        check("stall_cnt", 48'(stall_count), STALL_ON != 0 ? 48'd3 : 48'd0);
        check("stall_sb", 48'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 48'd0);
        // start with k_len=0 is ignored
        @(posedge Clock); #1;
        start = 1; k_len = 0;
        @(posedge Clock); #1;
        start = 0;
        cnt = 0;
        repeat (4) begin
            cnt += int'(busy) + int'(arr_clear);
            @(posedge Clock); #1;
        end
        check("k0_ignored", 48'(cnt), 48'd0);
        check("stall_hold", 48'(stall_count), STALL_ON != 0 ? 48'd3 : 48'd0);
        // asynchronous reset in the middle of FEED
        start = 1; k_len = 8'd5;
        @(posedge Clock); #1;
        start = 0; in_valid = 1; in_data = beat(7);
        repeat (3) @(posedge Clock);
        #3 Reset_n = 0;
        #1;
        check("mid_rst_ctrl", 48'({in_ready, arr_clear, arr_en, busy, done, arr_valid}), 48'h0);
        check("mid_rst_data", 48'(arr_data), 48'h0);
        check("mid_rst_stall", 48'(stall_count), 48'h0);
        in_valid = 0;
        for (int i = 0; i < N; i++) sbq[i].delete();
        repeat (2) @(posedge Clock);
        #1 Reset_n = 1;
        cnt = 0;
        repeat (12) begin
            @(posedge Clock); #1;
            cnt += int'(done) + int'(busy);
        end
        check("post_rst_idle", 48'(cnt), 48'd0);
        // maximum k_len
        run(255, 0, 0, 0, d, b, c);
        check("kmax_done_cyc", 48'(d), 48'd260);
        check("kmax_busy", 48'(b), 48'd260);
        check("kmax_sb", 48'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 48'd0);
        // longer run with a mid-stream stall
        run(6, 3, 2, 0, d, b, c);
        check("mix_done_cyc", 48'(d), 48'd13);
        check("mix_gaps", 48'(en_gaps(d)), 48'd2);
        check("mix_stall_cnt", 48'(stall_count), STALL_ON != 0 ? 48'd2 : 48'd0);
        check("mix_sb", 48'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 48'd0);
        repeat (3) @(posedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/matmul_feed_controller.md
# matmul_feed_controller

Sequencer that feeds operand vectors into the systolic multiply array. It accepts one N-lane operand beat per cycle over a valid/ready handshake and applies the diagonal skew internally: lane i is delayed i+1 enabled stages, built as per-lane register chains. It clears the array accumulators before a run, drains the skew pipeline after the last beat, and signals completion. It sits between the operand buffer and the processing-element array.

## Interface
- N, 3: lane count (array dimension), N ≥ 1
- W, 16: operand width per lane
- KW, 8: width of k_len and the beat counter
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a run; honoured only in IDLE
- k_len  in  KW  beats per run; latched on the accepted start
- in_valid  in  1  operand beat valid
- in_ready  out  1  controller accepts a beat
- in_data  in  N*W  lane i at [i*W +: W]
- arr_clear  out  1  one-cycle accumulator-clear pulse
- arr_en  out  1  array samples arr_data/arr_valid this cycle
- arr_data  out  N*W  skewed operand lanes
- arr_valid  out  N  per-lane flag: real operand (1) or drain filler (0)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- stall_count  out  16  FEED cycles with in_valid low (see Configuration)

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: when start=1 and k_len≠0, latch k_len, clear beat and drain counters, go to CLEAR. start with k_len=0 is ignored.
- CLEAR: arr_clear=1 for exactly one cycle, then go to FEED.
- FEED: in_ready=1. A beat transfers when in_valid & in_ready. After the k_len-th transfer, go to DRAIN.
- DRAIN: inject zero data with valid=0 for exactly N cycles, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Shift enable sh = (FEED & in_valid) | DRAIN. The skew registers and the beat counter advance only when sh=1.
- A FEED cycle with in_valid=0 freezes every skew stage and keeps the diagonal alignment.
- Lane i chain has i+1 stages. Stage 0 loads in_data lane i together with valid=1 (FEED) or zero with valid=0 (DRAIN).
- arr_en is sh registered one cycle, so it is aligned with the updated chain outputs.
- start while busy is ignored. in_data is ignored outside FEED.

## Timing
- Reset values: state=IDLE. in_ready, arr_clear, arr_en, busy and done are 0. arr_data, arr_valid and all chain stages are 0. stall_count=0. Reset asserted mid-run aborts immediately; no done is produced.
- Without stalls, the edge accepting start is followed by 1 CLEAR + k_len FEED + N DRAIN cycles and 1 DONE cycle. busy stays high for k_len+N+2 cycles.
- Beat j accepted at enabled edge e: lane i presents it after the (i+1)-th enabled edge from e inclusive. With no stalls, lane i shows it in the cycle after edge e+i, with arr_en=1.
- The last beat reaches lane N-1 on the final DRAIN shift. The arr_en of that shift is high in the DONE cycle.
- The beat counter saturates at k_len and never wraps. k_len=2^KW-1 is legal.

## Configuration
- MATMUL_FEED_STALL_CNT_EN defined: stall_count increments on each FEED cycle with in_valid=0. It saturates at 16'hFFFF, clears on each accepted start, and holds its value after DONE.
- Macro undefined: no counter logic is built and stall_count is tied to 0.

## Test plan
(all with N=3, W=16, KW=8)
- Reset mid-run: assert Reset_n=0 during FEED -> all outputs 0 asynchronously; after release, state is IDLE and done never pulses.
- Basic run: start with k_len=4, in_valid held 1, lane0 beats 16'h0001..16'h0004 -> arr_clear pulse 1 cycle after start; lane0 shows 0001 one cycle after its accept; lane2 shows the same beat's data 2 cycles later; done exactly 9 cycles after the start edge (1 CLEAR + 4 FEED + 3 DRAIN + DONE); busy high 9 cycles.
- Stall: k_len=2, in_valid low for 3 cycles between beats -> arr_en low 3 cycles and skew alignment preserved; stall_count=3 with MATMUL_FEED_STALL_CNT_EN defined, 0 without it.
- Ignored starts: start with k_len=0 -> busy stays 0; start pulsed during FEED -> no restart and no second arr_clear.
- Drain flags: after the last beat, arr_valid runs 3'b110, 3'b100, 3'b000 on the N=3 drain shifts; arr_data lanes carrying filler read 0.
- Back-to-back: start asserted in the cycle after done -> new CLEAR pulse; the latched k_len is the new value.
